// File: rtl/scoot_bot_controller_if.sv
// Sense/move handshake bundle between the bot controller and the grid simulator.
// master = controller side, slave = simulator side.
interface scoot_bot_controller_if #(
    parameter int NUM_DIRS = 4
) ();
    logic [NUM_DIRS-1:0] sense;
    logic                senseValid;
    logic                moveValid;
    logic                moveReady;
    logic [NUM_DIRS-1:0] moveDir;

    modport master (
        input  sense,
        input  senseValid,
        input  moveReady,
        output moveValid,
        output moveDir
    );

    modport slave (
        output sense,
        output senseValid,
        output moveReady,
        input  moveValid,
        input  moveDir
    );
endinterface

// File: rtl/scoot_bot_controller.sv
// Grid bot controller: sense capture + history, rotating-priority move choice, LFSR wander, pickup count.
// Move registered 1 cycle after capture, held until moveReady; optional SCOOT_ANTI_REVERSE_EN masks reversals.
module scoot_bot_controller #(
    parameter int          NUM_DIRS    = 4,
    parameter int          HIST_DEPTH  = 2,
    parameter int          IDLE_LIMIT  = 4,
    parameter int          COUNT_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                       clock,
    input  logic                       resetN,
    scoot_bot_controller_if.master     bus,
    input  logic                       pickup,
    output logic [COUNT_WIDTH-1:0]     foodCount,
    output logic                       busy
);
    localparam int          IW        = $clog2(NUM_DIRS);
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  IDLE_MAX  = 8'(IDLE_LIMIT);

    typedef enum logic {SENSE, MOVE} state_t;

    state_t                   state_q, state_d;
    logic [NUM_DIRS-1:0]      move_dir_q, move_dir_d;
    logic [IW-1:0]            dir_idx_q, dir_idx_d;
    logic [IW-1:0]            last_idx_q, last_idx_d;
    logic [7:0]               idle_q, idle_d;
    logic [NUM_DIRS-1:0]      hist_q [HIST_DEPTH];
    logic [NUM_DIRS-1:0]      hist_d [HIST_DEPTH];
    logic [15:0]              lfsr_q, lfsr_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    logic                     capture;
    logic [NUM_DIRS-1:0]      eff;
    logic [NUM_DIRS-1:0]      cand;
    logic [IW-1:0]            rev_idx;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            pick;
    logic [IW-1:0]            choice;
    logic [7:0]               idle_inc;

    assign bus.moveValid = (state_q == MOVE);
    assign bus.moveDir   = move_dir_q;
    assign busy          = (state_q == MOVE);
    assign foodCount     = count_q;

    assign capture = (state_q == SENSE) && bus.senseValid;
    assign rev_idx = last_idx_q + IW'(NUM_DIRS / 2);

    always_comb begin
        eff = bus.sense;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            eff = eff | hist_q[i];
        end
    end

`ifdef SCOOT_ANTI_REVERSE_EN
    // Drop the reverse of the last move unless it is the only way out.
    always_comb begin
        cand = eff & ~(NUM_DIRS'(1) << rev_idx);
        if (cand == '0) begin
            cand = eff;
        end
    end
`else
    assign cand = eff;
`endif

    // Rotating priority: first set candidate at or above last_idx_q, wrapping.
    always_comb begin
        pick = last_idx_q;
        idx  = last_idx_q;
        for (int k = NUM_DIRS - 1; k >= 0; k--) begin
            idx = last_idx_q + IW'(k);
            if (cand[idx]) begin
                pick = idx;
            end
        end
    end

    assign idle_inc = (idle_q >= IDLE_MAX) ? IDLE_MAX : idle_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        move_dir_d = move_dir_q;
        dir_idx_d  = dir_idx_q;
        last_idx_d = last_idx_q;
        idle_d     = idle_q;
        choice     = last_idx_q;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        count_d = count_q;

        case (state_q)
            SENSE: begin
                if (capture) begin
                    if (eff != '0) begin
                        idle_d = 8'd0;
                        choice = pick;
                    end else begin
                        idle_d = idle_inc;
                        choice = (idle_inc == IDLE_MAX) ? lfsr_q[IW-1:0] : last_idx_q;
                    end
                    hist_d[0] = bus.sense;
                    for (int i = 1; i < HIST_DEPTH; i++) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    dir_idx_d  = choice;
                    move_dir_d = NUM_DIRS'(1) << choice;
                    state_d    = MOVE;
                end
            end
            MOVE: begin
                if (bus.moveReady) begin
                    last_idx_d = dir_idx_q;
                    state_d    = SENSE;
                end
            end
            default: state_d = SENSE;
        endcase

        // Pickup overrides any idle increment from a same-cycle empty capture.
        if (pickup) begin
            idle_d = 8'd0;
            if (count_q != {COUNT_WIDTH{1'b1}}) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= SENSE;
            move_dir_q <= '0;
            dir_idx_q  <= '0;
            last_idx_q <= '0;
            idle_q     <= 8'd0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            lfsr_q     <= SEED_EFF;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            move_dir_q <= (state_d == MOVE) ? move_dir_d : '0;
            dir_idx_q  <= dir_idx_d;
            last_idx_q <= last_idx_d;
            idle_q     <= idle_d;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            lfsr_q     <= lfsr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_scoot_bot_controller.sv
// Directed bench for scoot_bot_controller: reset, handshake, history, anti-reverse, wander, counter.
module tb_scoot_bot_controller;
    localparam int CW = 8;

    logic          clock;
    logic          resetN;
    logic          pickup;
    logic [CW-1:0] foodCount;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model_lfsr;
    logic [15:0] snap;
    logic [1:0]  w;
    logic [3:0]  exp_dir;

    scoot_bot_controller_if #(.NUM_DIRS(4)) bif ();

    scoot_bot_controller #(
        .NUM_DIRS    (4),
        .HIST_DEPTH  (2),
        .IDLE_LIMIT  (4),
        .COUNT_WIDTH (CW),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .bus       (bif),
        .pickup    (pickup),
        .foodCount (foodCount),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference Galois LFSR, x^16+x^14+x^13+x^11+1, free-running out of reset.
    always @(posedge clock or negedge resetN) begin
        if (!resetN) model_lfsr <= 16'hACE1;
        else         model_lfsr <= {1'b0, model_lfsr[15:1]} ^ (model_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [3:0] s, input logic pk);
        @(negedge clock);
        bif.sense      = s;
        bif.senseValid = 1'b1;
        pickup         = pk;
        snap           = model_lfsr;
        @(negedge clock);
        bif.senseValid = 1'b0;
        bif.sense      = 4'b0000;
        pickup         = 1'b0;
    endtask

    task automatic accept(input string tag);
        @(negedge clock);
        bif.moveReady = 1'b1;
        @(negedge clock);
        bif.moveReady = 1'b0;
        check({tag, "_acc_vld"}, 32'(bif.moveValid), 32'd0);
    endtask

    task automatic step(input string tag, input logic [3:0] s, input logic pk, input logic [3:0] exp);
        capture(s, pk);
        check({tag, "_vld"}, 32'(bif.moveValid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_dir"}, 32'(bif.moveDir), 32'(exp));
        accept(tag);
    endtask

    initial begin
        resetN         = 1'b0;
        pickup         = 1'b0;
        bif.sense      = 4'b0000;
        bif.senseValid = 1'b0;
        bif.moveReady  = 1'b0;

        // 1. Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bif.sense      = 4'($urandom);
            bif.senseValid = 1'($urandom);
            bif.moveReady  = 1'($urandom);
            pickup         = 1'($urandom);
        end
        @(negedge clock);
        check("rst_vld", 32'(bif.moveValid), 32'd0);
        check("rst_dir", 32'(bif.moveDir), 32'd0);
        check("rst_cnt", 32'(foodCount), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        bif.sense      = 4'b0000;
        bif.senseValid = 1'b0;
        bif.moveReady  = 1'b0;
        pickup         = 1'b0;
        #2 resetN = 1'b1;

        step("t1_empty", 4'b0000, 1'b0, 4'b0001);

        // 2. Latency and stall: sense ignored while the move is pending
        capture(4'b0010, 1'b0);
        check("t2_vld", 32'(bif.moveValid), 32'd1);
        check("t2_dir", 32'(bif.moveDir), 32'h2);
        bif.senseValid = 1'b1;
        bif.sense      = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_hold_dir", 32'(bif.moveDir), 32'h2);
            check("t2_hold_vld", 32'(bif.moveValid), 32'd1);
        end
        bif.senseValid = 1'b0;
        bif.sense      = 4'b0000;
        accept("t2");

        // 3. History carries the last food sighting
        step("t3_a", 4'b0010, 1'b0, 4'b0010);
        step("t3_h1", 4'b0000, 1'b0, 4'b0010);
        step("t3_h2", 4'b0000, 1'b0, 4'b0010);
        step("t3_last", 4'b0000, 1'b0, 4'b0010);

        // Pickup alongside an empty capture resets the idle run
        step("t3_pk", 4'b0000, 1'b1, 4'b0010);
        check("t3_cnt1", 32'(foodCount), 32'd1);

        // 5. Wander on the fourth consecutive empty capture
        step("t5_i1", 4'b0000, 1'b0, 4'b0010);
        step("t5_i2", 4'b0000, 1'b0, 4'b0010);
        step("t5_i3", 4'b0000, 1'b0, 4'b0010);
        capture(4'b0000, 1'b0);
        w       = snap[1:0];
        exp_dir = 4'b0001 << w;
        check("t5_wander_dir", 32'(bif.moveDir), 32'(exp_dir));
        accept("t5_wander");
        @(negedge clock);
        pickup = 1'b1;
        @(negedge clock);
        pickup = 1'b0;
        check("t5_cnt2", 32'(foodCount), 32'd2);
        step("t5_after", 4'b0000, 1'b0, exp_dir);

        // 4. Anti-reverse / rotation, from lastDir=right with clean history
        step("t4_anchor", 4'b0010, 1'b0, 4'b0010);
        step("t4_clr1", 4'b0000, 1'b0, 4'b0010);
        step("t4_clr2", 4'b0000, 1'b0, 4'b0010);
        step("t4_1100", 4'b1100, 1'b0, 4'b0100);
        step("t4_h1", 4'b0000, 1'b0, 4'b0100);
        step("t4_h2", 4'b0000, 1'b0, 4'b0100);
`ifdef SCOOT_ANTI_REVERSE_EN
        exp_dir = 4'b0010;
`else
        exp_dir = 4'b0001;
`endif
        step("t4_0011", 4'b0011, 1'b0, exp_dir);
        step("t4_h3", 4'b0000, 1'b0, exp_dir);
        step("t4_h4", 4'b0000, 1'b0, exp_dir);
        step("t4_only", 4'b1000, 1'b0, 4'b1000);

        // 6. Counter saturation
        @(negedge clock);
        pickup = 1'b1;
        repeat (98) @(negedge clock);
        pickup = 1'b0;
        check("t6_cnt100", 32'(foodCount), 32'd100);
        pickup = 1'b1;
        repeat ((1 << CW) + 3) @(negedge clock);
        pickup = 1'b0;
        check("t6_sat", 32'(foodCount), 32'hFF);
        @(negedge clock);
        check("t6_sat_hold", 32'(foodCount), 32'hFF);

        // Asynchronous reset mid-MOVE
        capture(4'b0001, 1'b0);
        check("t6_pre_vld", 32'(bif.moveValid), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check("t6_ar_vld", 32'(bif.moveValid), 32'd0);
        check("t6_ar_busy", 32'(busy), 32'd0);
        check("t6_ar_dir", 32'(bif.moveDir), 32'd0);
        check("t6_ar_cnt", 32'(foodCount), 32'd0);
        @(negedge clock);
        #2 resetN = 1'b1;
        step("t6_post", 4'b0000, 1'b0, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/scoot_bot_controller.md
Name: scoot_bot_controller

Overview:
Parametrised successor to the grid-walker bot controller.
- Samples a NUM_DIRS-wide neighbour food-sense vector and ORs it with a HIST_DEPTH-deep sense history.
- Arbitrates to exactly one one-hot move per step and hands the move to the grid simulator over a valid/ready handshake.
- Wanders pseudo-randomly when no food has been sensed for IDLE_LIMIT steps, and keeps a saturating pickup count.

Parameters:
NUM_DIRS, 4, number of move/sense directions; power of two, 4 or 8. Bit i's reverse is (i+NUM_DIRS/2)%NUM_DIRS. For 4: bit0 up, bit1 right, bit2 down, bit3 left.
HIST_DEPTH, 2, number of past captured sense vectors ORed into the decision (1..8).
IDLE_LIMIT, 4, consecutive empty captures before wandering (1..255).
COUNT_WIDTH, 16, foodCount width.
LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001.

Ports:
clock  input  1  single clock, rising edge
resetN  input  1  asynchronous, active-low reset
sense  input  NUM_DIRS  food present in each neighbour cell
senseValid  input  1  sense is valid this cycle
moveValid  output  1  moveDir holds a pending move
moveReady  input  1  simulator accepts the move
moveDir  output  NUM_DIRS  one-hot move direction
pickup  input  1  single-cycle pulse: food collected at the current cell
foodCount  output  COUNT_WIDTH  saturating pickup count
busy  output  1  high while in MOVE state

Behaviour:
Reset values (asynchronous; take effect immediately, including mid-handshake):
- state=SENSE; moveValid=0; moveDir=0; busy=0; foodCount=0.
- lastDir=0; idleCount=0; history all-zero; LFSR=seed.

LFSR:
- 16-bit Galois, taps 16,14,13,11.
- Advances every cycle out of reset.
- wanderDir = LFSR[log2(NUM_DIRS)-1:0].

SENSE state:
- senseValid=1 is a capture.
- eff = sense OR all history entries.
- On capture, history shifts: the newest entry becomes sense and the oldest is dropped.
- Next state is MOVE; moveValid and moveDir become registered at the next edge (1-cycle latency from the capture edge).

Decision on capture:
- eff!=0: idleCount cleared. Candidates = eff, masked per the optional feature. Search from lastDir upward, modulo NUM_DIRS; the first set bit wins.
- eff==0: idleCount increments, saturating at IDLE_LIMIT. If the new value equals IDLE_LIMIT, the choice is wanderDir; otherwise lastDir.

MOVE state:
- moveValid=1 and busy=1.
- moveDir is held stable, and senseValid is ignored, until moveReady=1 at an edge.
- On acceptance: lastDir is updated, state returns to SENSE, and moveValid drops at that edge.
- moveReady is ignored in SENSE.
- moveDir is always exactly one-hot while moveValid=1.

pickup:
- Accepted in any state.
- foodCount increments and saturates at all-ones.
- idleCount is cleared.
- If a capture with eff==0 and pickup occur in the same cycle, pickup wins and idleCount ends at 0.

Optional Feature:
SCOOT_ANTI_REVERSE_EN
- Defined: if candidates contain any bit other than reverse(lastDir), the reverse bit is cleared before the search. If the reverse is the only set bit, it is chosen.
- Undefined: no masking; plain rotating priority from lastDir.

Test Plan:
1. Reset: hold resetN=0 with random inputs -> moveValid=0, moveDir=0, foodCount=0, busy=0. Then release, capture sense=4'b0000 -> moveDir=4'b0001 (lastDir up, idleCount=1).
2. Latency/handshake: capture sense=4'b0010 -> moveValid=1, moveDir=4'b0010 the next cycle. Hold moveReady=0 for 5 cycles while driving senseValid=1 with sense=4'b0100 -> moveDir stays 4'b0010. Set moveReady=1 -> moveValid=0 next cycle, lastDir=right.
3. History (HIST_DEPTH=2): capture 4'b0010, accept, then capture 4'b0000 -> moveDir=4'b0010 from history; third capture of 4'b0000 (history now 0010,0000) still 0010; fourth -> lastDir repeat with idleCount counting.
4. Anti-reverse (macro defined, lastDir=right): capture 4'b1000|4'b0100=4'b1100 -> moveDir=4'b0100. Capture 4'b1000 alone -> 4'b1000. Macro undefined, lastDir=right, capture 4'b1100 -> 4'b0100 by rotation from right.
5. Wander: IDLE_LIMIT=4, seed 16'hACE1, sense=0, history cleared. Captures 1-3 -> moveDir=lastDir. Capture 4 -> moveDir matches the reference-model LFSR low bits. Then pulse pickup and capture 0 -> lastDir again (idleCount=1).
6. Counter/reset: preload by pulsing pickup 2^COUNT_WIDTH+3 times -> foodCount stays all-ones. Assert resetN=0 mid-MOVE -> moveValid falls without waiting for a clock edge; foodCount=0.
